// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0] BCD_ADJ = 4'd3;

    // Decimal digits needed to show every value of a w-bit unsigned operand.
    function automatic int unsigned digits_for_width(input int unsigned w);
        return (w * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble add-3 correction for one BCD digit; no carry leaves the digit.
module bcd_digit_adj
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = (digit >= 4'd5) ? digit + BCD_ADJ : digit;
    end

endmodule

// File: rtl/module_bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one operand bit per cycle (double dabble),
// with valid/ready handshakes on the request and result sides.
module module_bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [WIDTH-1:0]      bin_i,
    output logic                  ready_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  overflow_o
);

    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
    localparam int unsigned WORK_W = 4 * DIGITS + WIDTH;

    generate
        if (WIDTH == 0 || DIGITS == 0) begin : g_bad_params
            $error("module_bin_to_bcd_seq: WIDTH and DIGITS must both be >= 1");
        end
    endgenerate

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     bin_sh;
    logic [4*DIGITS-1:0]  digits;
    logic [4*DIGITS-1:0]  adjusted;
    logic [WORK_W-1:0]    work;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf;
    logic                 carry;
    logic                 last;

    generate
        for (genvar k = 0; k < int'(DIGITS); k++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (digits[4*k +: 4]),
                .adjusted (adjusted[4*k +: 4])
            );
        end
    endgenerate

    // The bit leaving the top digit is dropped, which keeps the digits exact mod 10^DIGITS.
    always_comb begin
        carry = adjusted[4*DIGITS-1];
        work  = {adjusted[4*DIGITS-2:0], bin_sh, 1'b0};
        last  = (cnt == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_i) state_next = SHIFT;
            SHIFT:   if (last)    state_next = DONE;
            DONE:    if (ready_i) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == IDLE);
        valid_o = (state == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_sh     <= '0;
            digits     <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            bcd_o      <= '0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        bin_sh <= bin_i;
                        digits <= '0;
                        ovf    <= 1'b0;
                        cnt    <= CNT_W'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    digits <= work[WORK_W-1:WIDTH];
                    bin_sh <= work[WIDTH-1:0];
                    ovf    <= ovf | carry;
                    if (last) begin
                        bcd_o      <= work[WORK_W-1:WIDTH];
                        overflow_o <= ovf | carry;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
